system_led_sequencer: RTL and testbench

Avalon-MM controller that drives the 8-bit LED PIO autonomously. The CPU loads a table of up to eight LED patterns, a step period and a mode over a slave port. The block then steps through the table, writing each pattern to the PIO through an Avalon-MM master port. It writes either the whole pattern (PIO offset 0) or only the changed bits (PIO set register offset 4, clear register offset 5). It sits between the CPU data master and the PIO slave in the system interconnect.

---
 rtl/system_led_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_system_led_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_led_sequencer.sv
// Autonomous LED pattern sequencer: a CPU-loaded table is stepped through and written to the
// LED PIO over an Avalon-MM master, either as full patterns or as set/clear deltas.
module system_led_sequencer #(
   parameter int unsigned PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          s_address,
   input  logic                s_chipselect,
   input  logic                s_write_n,
   input  logic                s_read_n,
   input  logic [31:0]         s_writedata,
   output logic [31:0]         s_readdata,
   output logic [2:0]          m_address,
   output logic                m_chipselect,
   output logic                m_write_n,
   output logic [31:0]         m_writedata,
   input  logic                m_waitrequest
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StFetch  = 3'd1;
   localparam logic [2:0] StWrFull = 3'd2;
   localparam logic [2:0] StWrSet  = 3'd3;
   localparam logic [2:0] StWrClr  = 3'd4;
   localparam logic [2:0] StWait   = 3'd5;

   logic [2:0]          state_q, state_d;
   logic                en_q, en_d;
   logic                loop_q, delta_q;
   logic                restart_q, restart_d, restart_nx;
   logic [PERIOD_W-1:0] period_q;
   logic [3:0]          length_q;
   logic [7:0]          tbl_q [8];
   logic [7:0]          shadow_q, shadow_d;
   logic [2:0]          index_q, index_d;
   logic [7:0]          pat_q, pat_d;
   logic [7:0]          set_q, set_d;
   logic [7:0]          clr_q, clr_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                fsm_clr_en;

   logic                wr, wr_ctrl, busy, accept, last;
   logic [3:0]          len_eff;
   logic [PERIOD_W-1:0] period_eff;
   logic [2:0]          fetch_idx;
   logic [7:0]          fetch_pat, fetch_set, fetch_clr;
   logic [31:0]         rdata;
   logic                unused_wdata;

   assign unused_wdata = ^s_writedata;

   assign wr         = s_chipselect & ~s_write_n;
   assign wr_ctrl    = wr && (s_address == 4'd0);
   assign busy       = (state_q != StIdle);
   assign accept     = m_chipselect & ~m_waitrequest;
   assign len_eff    = (length_q == 4'd0) ? 4'd1 : ((length_q > 4'd8) ? 4'd8 : length_q);
   assign period_eff = (period_q == '0) ? {{(PERIOD_W-1){1'b0}}, 1'b1} : period_q;
   assign last       = ({1'b0, index_q} == (len_eff - 4'd1));

   // A pending restart redirects the very next fetch to entry 0
   assign fetch_idx = restart_q ? 3'd0 : index_q;
   assign fetch_pat = tbl_q[fetch_idx];
   assign fetch_set = fetch_pat & ~shadow_q;
   assign fetch_clr = shadow_q & ~fetch_pat;

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      pat_d      = pat_q;
      set_d      = set_q;
      clr_d      = clr_q;
      shadow_d   = shadow_q;
      cnt_d      = cnt_q;
      restart_d  = restart_q;
      fsm_clr_en = 1'b0;
      case (state_q)
         StIdle: begin
            restart_d = 1'b0;
            if (wr_ctrl && s_writedata[0]) begin
               index_d = 3'd0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            pat_d     = fetch_pat;
            set_d     = fetch_set;
            clr_d     = fetch_clr;
            index_d   = fetch_idx;
            restart_d = 1'b0;
            if (!delta_q) begin
               state_d = StWrFull;
            end else if (fetch_set != 8'd0) begin
               state_d = StWrSet;
            end else if (fetch_clr != 8'd0) begin
               state_d = StWrClr;
            end else begin
               state_d = StWait;
               cnt_d   = period_eff;
            end
         end
         StWrFull: begin
            if (accept) begin
               shadow_d = pat_q;
               state_d  = en_q ? StWait : StIdle;
               cnt_d    = period_eff;
            end
         end
         StWrSet: begin
            if (accept) begin
               shadow_d = shadow_q | set_q;
               cnt_d    = period_eff;
               if (!en_q) begin
                  state_d = StIdle;
               end else if (clr_q != 8'd0) begin
                  state_d = StWrClr;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWrClr: begin
            if (accept) begin
               shadow_d = shadow_q & ~clr_q;
               state_d  = en_q ? StWait : StIdle;
               cnt_d    = period_eff;
            end
         end
         StWait: begin
            if (!en_q) begin
               state_d = StIdle;
            end else if (restart_q) begin
               state_d = StFetch;
            end else if (cnt_q <= {{(PERIOD_W-1){1'b0}}, 1'b1}) begin
               if (last && !loop_q) begin
                  fsm_clr_en = 1'b1;
                  state_d    = StIdle;
               end else begin
                  // Also wraps an index left beyond a LENGTH that shrank mid-run
                  index_d = (({1'b0, index_q} + 4'd1) >= len_eff) ? 3'd0 : (index_q + 3'd1);
                  state_d = StFetch;
               end
            end else begin
               cnt_d = cnt_q - {{(PERIOD_W-1){1'b0}}, 1'b1};
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // CPU writes to CTRL take priority over the sequencer's own end-of-run EN clear
   always_comb begin
      en_d = en_q;
      if (fsm_clr_en) en_d = 1'b0;
      if (wr_ctrl) en_d = s_writedata[0];
      restart_nx = restart_d | (wr_ctrl & s_writedata[3] & busy);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         en_q      <= 1'b0;
         loop_q    <= 1'b0;
         delta_q   <= 1'b0;
         restart_q <= 1'b0;
         period_q  <= '0;
         length_q  <= 4'd0;
         shadow_q  <= 8'd0;
         index_q   <= 3'd0;
         pat_q     <= 8'd0;
         set_q     <= 8'd0;
         clr_q     <= 8'd0;
         cnt_q     <= '0;
         for (int i = 0; i < 8; i++) tbl_q[i] <= 8'd0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         restart_q <= restart_nx;
         shadow_q  <= shadow_d;
         index_q   <= index_d;
         pat_q     <= pat_d;
         set_q     <= set_d;
         clr_q     <= clr_d;
         cnt_q     <= cnt_d;
         if (wr_ctrl) begin
            loop_q  <= s_writedata[1];
            delta_q <= s_writedata[2];
         end
         if (wr && (s_address == 4'd2)) period_q <= s_writedata[PERIOD_W-1:0];
         if (wr && (s_address == 4'd3)) length_q <= s_writedata[3:0];
         if (wr && s_address[3]) tbl_q[s_address[2:0]] <= s_writedata[7:0];
      end
   end

   always_comb begin
      m_chipselect = 1'b0;
      m_address    = 3'd0;
      m_writedata  = 32'd0;
      case (state_q)
         StWrFull: begin
            m_chipselect = 1'b1;
            m_writedata  = {24'd0, pat_q};
         end
         StWrSet: begin
            m_chipselect = 1'b1;
            m_address    = 3'd4;
            m_writedata  = {24'd0, set_q};
         end
         StWrClr: begin
            m_chipselect = 1'b1;
            m_address    = 3'd5;
            m_writedata  = {24'd0, clr_q};
         end
         default: ;
      endcase
      m_write_n = ~m_chipselect;
   end

   always_comb begin
      rdata = 32'd0;
      case (s_address)
         4'd0: rdata[2:0] = {delta_q, loop_q, en_q};
         4'd1: begin
            rdata[0]    = busy;
            rdata[10:8] = index_q;
         end
         4'd2: rdata[PERIOD_W-1:0] = period_q;
         4'd3: rdata[3:0] = length_q;
         default: if (s_address[3]) rdata[7:0] = tbl_q[s_address[2:0]];
      endcase
      s_readdata = (s_chipselect && !s_read_n) ? rdata : 32'd0;
   end

endmodule

// File: tb/tb_system_led_sequencer.sv
// Scoreboard bench for system_led_sequencer: a list-level model predicts PIO writes, a monitor
// pops and compares every cycle the DUT requests the bus.
module tb_system_led_sequencer;

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  s_address;
   logic        s_chipselect, s_write_n, s_read_n;
   logic [31:0] s_writedata, s_readdata;
   logic [2:0]  m_address;
   logic        m_chipselect, m_write_n, m_waitrequest;
   logic [31:0] m_writedata;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   n_acc = 0;
   int   wr_mode = 0;
   bit   mon_en = 1'b1;
   int   acc_times[$];
   wr_t  exp_q[$];
   logic [7:0] tbl [8];
   logic [7:0] m_shadow = 8'd0;

   system_led_sequencer #(.PERIOD_W(24)) dut (
      .clk          (clk),
      .reset        (reset),
      .s_address    (s_address),
      .s_chipselect (s_chipselect),
      .s_write_n    (s_write_n),
      .s_read_n     (s_read_n),
      .s_writedata  (s_writedata),
      .s_readdata   (s_readdata),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata),
      .m_waitrequest(m_waitrequest)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [2:0] a, input logic [7:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   // Expected PIO traffic for one non-looping pass over the table
   task automatic model_run(input logic [3:0] len, input bit delta);
      int le;
      logic [7:0] p, s, c;
      le = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
      for (int i = 0; i < le; i++) begin
         p = tbl[i];
         if (!delta) begin
            push_exp(3'd0, p);
         end else begin
            s = p & ~m_shadow;
            c = m_shadow & ~p;
            if (s != 0) push_exp(3'd4, s);
            if (c != 0) push_exp(3'd5, c);
         end
         m_shadow = p;
      end
   endtask

   task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      s_chipselect = 1'b1;
      s_write_n    = 1'b0;
      s_address    = a;
      s_writedata  = d;
      @(negedge clk);
      s_chipselect = 1'b0;
      s_write_n    = 1'b1;
   endtask

   task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      s_chipselect = 1'b1;
      s_read_n     = 1'b0;
      s_address    = a;
      #1;
      d            = s_readdata;
      s_chipselect = 1'b0;
      s_read_n     = 1'b1;
   endtask

   task automatic load_table();
      for (int i = 0; i < 8; i++) wr_reg(4'(8 + i), {24'd0, tbl[i]});
   endtask

   task automatic wait_idle(input int budget);
      logic [31:0] st;
      int n;
      n = 0;
      do begin
         rd_reg(4'd1, st);
         n++;
      end while (st[0] && n < budget);
      chk("busy_after_run", {31'd0, st[0]}, 32'd0);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      int stall;
      stall = 0;
      m_waitrequest = 1'b0;
      forever begin
         @(negedge clk);
         case (wr_mode)
            1: m_waitrequest = ($urandom_range(0, 3) == 0);
            2: begin
               if (m_chipselect && stall < 5) begin
                  m_waitrequest = 1'b1;
                  stall++;
               end else begin
                  m_waitrequest = 1'b0;
                  stall = 0;
               end
            end
            3: m_waitrequest = 1'b1;
            default: m_waitrequest = 1'b0;
         endcase
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mon_en && m_chipselect) begin
            chk("m_write_n", {31'd0, m_write_n}, 32'd0);
            if (exp_q.size() == 0) begin
               if (!m_waitrequest) begin
                  vectors++;
                  miscompares++;
                  n_acc++;
                  $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                           m_address, m_writedata);
               end
            end else begin
               chk("m_address", {29'd0, m_address}, {29'd0, exp_q[0].addr});
               chk("m_writedata", m_writedata, {24'd0, exp_q[0].data});
               if (!m_waitrequest) begin
                  void'(exp_q.pop_front());
                  acc_times.push_back(cyc);
                  n_acc++;
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] rd;
      int base;
      bit found;
      logic [3:0] len;
      bit dl;

      reset = 1'b1;
      s_address = 4'd0;
      s_chipselect = 1'b0;
      s_write_n = 1'b1;
      s_read_n = 1'b1;
      s_writedata = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_m_chipselect", {31'd0, m_chipselect}, 32'd0);
      chk("rst_m_write_n", {31'd0, m_write_n}, 32'd1);
      chk("rst_m_address", {29'd0, m_address}, 32'd0);
      chk("rst_m_writedata", m_writedata, 32'd0);
      rd_reg(4'd1, rd); chk("rst_status", rd, 32'd0);
      rd_reg(4'd0, rd); chk("rst_ctrl", rd, 32'd0);

      // Register readback
      wr_reg(4'd2, 32'hFF12_3456); rd_reg(4'd2, rd); chk("period_rb", rd, 32'h0012_3456);
      wr_reg(4'd3, 32'h1F);        rd_reg(4'd3, rd); chk("length_rb", rd, 32'hF);
      wr_reg(4'd9, 32'h1A5);       rd_reg(4'd9, rd); chk("table_rb", rd, 32'hA5);
      rd_reg(4'd5, rd); chk("unmapped_rd", rd, 32'd0);

      // Full-pattern run with start latency and spacing
      tbl = '{8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      load_table();
      wr_reg(4'd2, 32'd4);
      wr_reg(4'd3, 32'd3);
      model_run(4'd3, 1'b0);
      acc_times.delete();
      wr_reg(4'd0, 32'd1);
      #1;
      chk("fetch_cycle_cs", {31'd0, m_chipselect}, 32'd0);
      @(negedge clk);
      #1;
      chk("first_cs", {31'd0, m_chipselect}, 32'd1);
      rd_reg(4'd0, rd); chk("ctrl_running", rd, 32'd1);
      wait_idle(200);
      chk("full_count", acc_times.size(), 3);
      if (acc_times.size() >= 3) begin
         chk("full_gap0", acc_times[1] - acc_times[0], 6);
         chk("full_gap1", acc_times[2] - acc_times[1], 6);
      end
      rd_reg(4'd0, rd); chk("ctrl_done", rd, 32'd0);
      rd_reg(4'd1, rd); chk("status_done", rd, 32'h200);

      // Delta mode: set then clear back-to-back, then a no-write step
      tbl[0] = 8'h0F; tbl[1] = 8'h3C; tbl[2] = 8'h3C;
      load_table();
      wr_reg(4'd2, 32'd2);
      model_run(4'd3, 1'b1);
      acc_times.delete();
      wr_reg(4'd0, 32'd5);
      wait_idle(200);
      chk("delta_count", acc_times.size(), 3);
      if (acc_times.size() >= 3) chk("set_clr_b2b", acc_times[2] - acc_times[1], 1);

      // Five-cycle waitrequest on every write
      tbl[0] = 8'($urandom); tbl[1] = 8'($urandom); tbl[2] = 8'h3C;
      load_table();
      wr_reg(4'd2, 32'd4);
      model_run(4'd3, 1'b0);
      acc_times.delete();
      wr_mode = 2;
      wr_reg(4'd0, 32'd1);
      wait_idle(300);
      wr_mode = 0;
      chk("stall_count", acc_times.size(), 3);
      if (acc_times.size() >= 3) begin
         chk("stall_gap0", acc_times[1] - acc_times[0], 11);
         chk("stall_gap1", acc_times[2] - acc_times[1], 11);
      end

      // Clear EN while WR_SET is held: no clear write follows
      push_exp(3'd4, 8'hC3);
      m_shadow = 8'hFF;
      base = n_acc;
      wr_mode = 3;
      wr_reg(4'd3, 32'd1);
      wr_reg(4'd8, 32'hC3);
      wr_reg(4'd0, 32'd5);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         #1;
         if (m_chipselect && m_address == 3'd4) found = 1'b1;
      end
      chk("wr_set_seen", {31'd0, found}, 32'd1);
      wr_reg(4'd0, 32'd4);
      wr_mode = 0;
      wait_idle(100);
      chk("en_clear_writes", n_acc - base, 1);

      // RESTART while waiting
      tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h44;
      load_table();
      wr_reg(4'd2, 32'd20);
      wr_reg(4'd3, 32'd3);
      push_exp(3'd0, 8'h11); push_exp(3'd0, 8'h22);
      push_exp(3'd0, 8'h11); push_exp(3'd0, 8'h22); push_exp(3'd0, 8'h44);
      m_shadow = 8'h44;
      base = n_acc;
      wr_reg(4'd0, 32'd1);
      for (int i = 0; i < 200 && (n_acc - base) < 2; i++) @(negedge clk);
      chk("restart_pre_writes", n_acc - base, 2);
      repeat (3) @(negedge clk);
      wr_reg(4'd0, 32'd9);
      wait_idle(500);

      // Looping with PERIOD=0, then reset while a write is stalled
      tbl[0] = 8'hA5; tbl[1] = 8'h5A;
      load_table();
      wr_reg(4'd2, 32'd0);
      wr_reg(4'd3, 32'd2);
      for (int i = 0; i < 20; i++) begin
         push_exp(3'd0, 8'hA5);
         push_exp(3'd0, 8'h5A);
      end
      acc_times.delete();
      base = n_acc;
      wr_reg(4'd0, 32'd3);
      repeat (60) @(negedge clk);
      chk("loop_progress", {31'd0, (n_acc - base) >= 15}, 32'd1);
      if (acc_times.size() >= 2) chk("loop_gap", acc_times[1] - acc_times[0], 3);
      mon_en = 1'b0;
      wr_mode = 3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         #1;
         if (m_chipselect) found = 1'b1;
      end
      chk("loop_cs_seen", {31'd0, found}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_cs", {31'd0, m_chipselect}, 32'd0);
      chk("mid_rst_write_n", {31'd0, m_write_n}, 32'd1);
      chk("mid_rst_addr", {29'd0, m_address}, 32'd0);
      chk("mid_rst_data", m_writedata, 32'd0);
      rd_reg(4'd1, rd); chk("mid_rst_status", rd, 32'd0);
      exp_q.delete();
      wr_mode = 0;
      mon_en = 1'b1;
      m_shadow = 8'h00;
      for (int i = 0; i < 8; i++) tbl[i] = 8'h00;

      // Shadow must be back to zero: a single delta step sets the whole pattern
      tbl[0] = 8'h81;
      wr_reg(4'd8, 32'h81);
      wr_reg(4'd3, 32'd1);
      model_run(4'd1, 1'b1);
      wr_reg(4'd0, 32'd5);
      wait_idle(100);

      // Randomized runs with random waitrequest
      for (int r = 0; r < 6; r++) begin
         len = (r == 0) ? 4'd12 : 4'($urandom_range(0, 15));
         dl = 1'($urandom_range(0, 1));
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) tbl[i] = (i == 0) ? m_shadow : tbl[i-1];
            else tbl[i] = 8'($urandom);
         end
         load_table();
         wr_reg(4'd2, 32'($urandom_range(0, 5)));
         wr_reg(4'd3, {28'd0, len});
         model_run(len, dl);
         wr_mode = 1;
         wr_reg(4'd0, {29'd0, dl, 2'b01});
         wait_idle(2000);
         wr_mode = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
